// File: rtl/ntt_pkg.sv
// Shared NTT definitions: ring constants and the polynomial-add sequencer state encoding.
package ntt_pkg;
    localparam int COEF_W = 16;
    localparam int Q      = 12289;
    localparam int N      = 1024;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;
endpackage

// File: rtl/ntt_polyadd_ctrl_if.sv
// Bus bundle between the polyadd sequencer and its source RAMs, adder and result RAM.
interface ntt_polyadd_ctrl_if #(
    parameter int ADDR_W = ntt_pkg::ADDR_W,
    parameter int DATA_W = ntt_pkg::COEF_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              add_en;
    logic              add_load;
    logic              add_lazy;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_a_pair;
    logic [DATA_W-1:0] add_b;
    logic              add_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data_a, rd_data_b,
        output add_en, add_load, add_lazy, add_a, add_a_pair,
        input  add_b, add_valid,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data_a, rd_data_b,
        input  add_en, add_load, add_lazy, add_a, add_a_pair,
        output add_b, add_valid,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns strobes/addresses across NTT stages.
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH-1];
endmodule

// File: rtl/ntt_polyadd_ctrl.sv
// Sequencer for coefficient-wise polynomial addition: streams A/B pairs into the adder
// at one per cycle and writes the adder results back in address order.
module ntt_polyadd_ctrl
    import ntt_pkg::*;
#(
    parameter int N       = ntt_pkg::N,
    parameter int ADDR_W  = ntt_pkg::ADDR_W,
    parameter int DATA_W  = ntt_pkg::COEF_W,
    parameter int RD_LAT  = 1,
    parameter int ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               lazy,
    output logic               busy,
    output logic               done,
    ntt_polyadd_ctrl_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;

    if (N != (1 << ADDR_W) || N < 4 || RD_LAT < 1 || ADD_LAT < 1) begin : g_param_check
        $error("ntt_polyadd_ctrl: unsupported parameter combination");
    end

    ctrl_state_t      state_reg;
    ctrl_state_t      state_next;
    logic [CNT_W-1:0] rd_cnt_reg;
    logic [CNT_W-1:0] wr_cnt_reg;
    logic             lazy_reg;
    logic             in_run;
    logic             rd_fire;
    logic             wr_fire;
    logic             load_dly;

    // Strobes are gated by reset so an abort takes effect in the very cycle it is asserted.
    assign in_run  = (state_reg == READ) || (state_reg == DRAIN);
    assign rd_fire = (state_reg == READ) && !reset;
    assign wr_fire = in_run && bus.add_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = READ;
            READ:    if (rd_cnt_reg == CNT_W'(N - 1)) state_next = DRAIN;
            DRAIN:   if (wr_fire && wr_cnt_reg == CNT_W'(N - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
            lazy_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                rd_cnt_reg <= '0;
                wr_cnt_reg <= '0;
                if (start) begin
                    lazy_reg <= lazy;
                end
            end
            if (rd_fire) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            end
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Operand pairs reach the adder RD_LAT cycles after their read strobe.
    ntt_delay_line #(
        .WIDTH (1),
        .DEPTH (RD_LAT)
    ) u_load_dly (
        .clk   (clk),
        .reset (reset),
        .din   (rd_fire),
        .dout  (load_dly)
    );

    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE) && !reset;

    assign bus.rd_en      = rd_fire;
    assign bus.rd_addr    = rd_cnt_reg[ADDR_W-1:0];
    assign bus.add_en     = !reset;
    assign bus.add_load   = load_dly;
    assign bus.add_lazy   = lazy_reg;
    assign bus.add_a      = bus.rd_data_a;
    assign bus.add_a_pair = bus.rd_data_b;
    assign bus.wr_en      = wr_fire;
    assign bus.wr_addr    = wr_cnt_reg[ADDR_W-1:0];
    assign bus.wr_data    = bus.add_b;
endmodule

// File: tb/tb_ntt_polyadd_ctrl.sv
// Bench for ntt_polyadd_ctrl: RAM and adder models around an N=8 and an N=1024 instance,
// table-driven runs plus hand-written sequences for the multi-cycle corner cases.
module tb_ntt_polyadd_ctrl;
    localparam int Q  = 12289;
    localparam int NS = 8;
    localparam int NF = 1024;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic lz;
        int   a_base;
        int   a_step;
        int   b_base;
        int   b_step;
        int   exp_first_wr;
        int   exp_last_wr;
        int   exp_done;
        int   exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int c0 = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_sum(input int a, input int b, input logic lz);
        if (lz) return 16'((a + b) & 16'hffff);
        return 16'((a + b) % Q);
    endfunction

    // Adder model: ADD_LAT=2, modular reduction by a single conditional subtract.
    function automatic logic [15:0] adder_model(input logic [15:0] a, input logic [15:0] b, input logic lz);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (!lz && s >= 17'(Q)) s = s - 17'(Q);
        return s[15:0];
    endfunction

    // ---------------- small instance (N=8) ----------------
    logic start_s = 1'b0, lazy_s = 1'b0, busy_s, done_s;
    ntt_polyadd_ctrl_if #(.ADDR_W(3), .DATA_W(16)) bus_s();
    ntt_polyadd_ctrl #(.N(NS), .ADDR_W(3), .DATA_W(16), .RD_LAT(1), .ADD_LAT(2)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .lazy(lazy_s),
        .busy(busy_s), .done(done_s), .bus(bus_s.master)
    );

    logic [15:0] mem_a_s [NS];
    logic [15:0] mem_b_s [NS];
    logic [15:0] ra_s = '0, rb_s = '0, d1_s = '0, d2_s = '0;
    logic        v1_s = 1'b0, v2_s = 1'b0;

    always @(posedge clk) begin
        if (bus_s.rd_en) begin
            ra_s <= mem_a_s[bus_s.rd_addr];
            rb_s <= mem_b_s[bus_s.rd_addr];
        end
        if (reset) begin
            v1_s <= 1'b0;
            v2_s <= 1'b0;
        end else if (bus_s.add_en) begin
            v1_s <= bus_s.add_load;
            d1_s <= adder_model(bus_s.add_a, bus_s.add_a_pair, bus_s.add_lazy);
            v2_s <= v1_s;
            d2_s <= d1_s;
        end
    end
    assign bus_s.rd_data_a = ra_s;
    assign bus_s.rd_data_b = rb_s;
    assign bus_s.add_valid = v2_s;
    assign bus_s.add_b     = d2_s;

    wr_t sb_s [$];
    int  wr_cycs_s [$];
    int  done_cycs_s [$];
    int  busy_cnt_s = 0, rd_n_s = 0, lazy_hi_s = 0;

    always @(negedge clk) begin
        if (bus_s.wr_en) begin
            wr_cycs_s.push_back(cyc);
            tests++;
            if (sb_s.size() == 0) begin
                fails++;
                $display("FAIL wr_s_unexpected: got addr %0d data %0d, expected no write",
                         bus_s.wr_addr, bus_s.wr_data);
            end else begin
                wr_t e;
                e = sb_s.pop_front();
                if (e.addr != 16'(bus_s.wr_addr) || e.data != bus_s.wr_data) begin
                    fails++;
                    $display("FAIL wr_s: got addr %0d data %0d, expected addr %0d data %0d",
                             bus_s.wr_addr, bus_s.wr_data, e.addr, e.data);
                end
            end
        end
        if (done_s) done_cycs_s.push_back(cyc);
        if (busy_s) busy_cnt_s++;
        if (bus_s.rd_en) rd_n_s++;
        if (busy_s && bus_s.add_lazy) lazy_hi_s++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_s();
        sb_s.delete();
        wr_cycs_s.delete();
        done_cycs_s.delete();
        busy_cnt_s = 0;
        rd_n_s     = 0;
        lazy_hi_s  = 0;
    endtask

    task automatic push_exp_s(input logic lz);
        for (int i = 0; i < NS; i++) begin
            wr_t e;
            e.addr = 16'(i);
            e.data = exp_sum(int'(mem_a_s[i]), int'(mem_b_s[i]), lz);
            sb_s.push_back(e);
        end
    endtask

    task automatic start_run_s(input logic lz);
        start_s = 1'b1;
        lazy_s  = lz;
        c0      = cyc;
        tick();
        start_s = 1'b0;
        lazy_s  = 1'b0;
    endtask

    task automatic wait_done_s(input int want);
        int k;
        k = 0;
        while (done_cycs_s.size() < want && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            tests++;
            fails++;
            $display("FAIL done_s_timeout: got %0d done pulses, expected %0d", done_cycs_s.size(), want);
        end
    endtask

    function automatic int first_of(input int q [$]);
        return (q.size() > 0) ? q[0] : -1000;
    endfunction

    function automatic int last_of(input int q [$]);
        return (q.size() > 0) ? q[q.size()-1] : -1000;
    endfunction

    task automatic run_vec_s(input vec_t v, input string tag);
        clear_s();
        for (int i = 0; i < NS; i++) begin
            mem_a_s[i] = 16'(v.a_base + v.a_step * i);
            mem_b_s[i] = 16'(v.b_base + v.b_step * i);
        end
        push_exp_s(v.lz);
        start_run_s(v.lz);
        wait_done_s(1);
        tick();
        check({tag, "_first_wr"}, first_of(wr_cycs_s) - c0, v.exp_first_wr);
        check({tag, "_last_wr"},  last_of(wr_cycs_s) - c0, v.exp_last_wr);
        check({tag, "_done_cyc"}, first_of(done_cycs_s) - c0, v.exp_done);
        check({tag, "_writes"},   wr_cycs_s.size(), NS);
        check({tag, "_dones"},    done_cycs_s.size(), 1);
        check({tag, "_busy_cyc"}, busy_cnt_s, v.exp_busy);
        check({tag, "_reads"},    rd_n_s, NS);
        check({tag, "_lazy"},     lazy_hi_s, v.lz ? v.exp_busy : 0);
        check({tag, "_sb_left"},  sb_s.size(), 0);
        check({tag, "_idle"},     int'(busy_s), 0);
        $display("[TB] %s: lazy=%0d writes=%0d done@%0d", tag, v.lz, wr_cycs_s.size(),
                 first_of(done_cycs_s) - c0);
    endtask

    // ---------------- full-size instance (N=1024) ----------------
    logic start_f = 1'b0, lazy_f = 1'b0, busy_f, done_f;
    ntt_polyadd_ctrl_if #(.ADDR_W(10), .DATA_W(16)) bus_f();
    ntt_polyadd_ctrl #(.N(NF), .ADDR_W(10), .DATA_W(16), .RD_LAT(1), .ADD_LAT(2)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .lazy(lazy_f),
        .busy(busy_f), .done(done_f), .bus(bus_f.master)
    );

    logic [15:0] mem_a_f [NF];
    logic [15:0] mem_b_f [NF];
    logic [15:0] ra_f = '0, rb_f = '0, d1_f = '0, d2_f = '0;
    logic        v1_f = 1'b0, v2_f = 1'b0;

    always @(posedge clk) begin
        if (bus_f.rd_en) begin
            ra_f <= mem_a_f[bus_f.rd_addr];
            rb_f <= mem_b_f[bus_f.rd_addr];
        end
        if (reset) begin
            v1_f <= 1'b0;
            v2_f <= 1'b0;
        end else if (bus_f.add_en) begin
            v1_f <= bus_f.add_load;
            d1_f <= adder_model(bus_f.add_a, bus_f.add_a_pair, bus_f.add_lazy);
            v2_f <= v1_f;
            d2_f <= d1_f;
        end
    end
    assign bus_f.rd_data_a = ra_f;
    assign bus_f.rd_data_b = rb_f;
    assign bus_f.add_valid = v2_f;
    assign bus_f.add_b     = d2_f;

    wr_t sb_f [$];
    int  wr_n_f = 0, wr_first_f = -1000, done_n_f = 0, done_cyc_f = -1000, bad_f = 0;

    always @(negedge clk) begin
        if (bus_f.wr_en) begin
            if (wr_n_f == 0) wr_first_f = cyc;
            wr_n_f++;
            tests++;
            if (sb_f.size() == 0) begin
                fails++;
                $display("FAIL wr_f_unexpected: got addr %0d, expected no write", bus_f.wr_addr);
            end else begin
                wr_t e;
                e = sb_f.pop_front();
                if (e.addr != 16'(bus_f.wr_addr) || e.data != bus_f.wr_data) begin
                    fails++;
                    bad_f++;
                    $display("FAIL wr_f: got addr %0d data %0d, expected addr %0d data %0d",
                             bus_f.wr_addr, bus_f.wr_data, e.addr, e.data);
                end
            end
        end
        if (done_f) begin
            done_n_f++;
            done_cyc_f = cyc;
        end
    end

    vec_t vecs [3];

    initial begin
        vecs[0] = '{lz: 1'b0, a_base: 12000, a_step: 1, b_base: 300,   b_step: 0,
                    exp_first_wr: 4, exp_last_wr: NS + 3, exp_done: NS + 4, exp_busy: NS + 4};
        vecs[1] = '{lz: 1'b1, a_base: 12288, a_step: 0, b_base: 12288, b_step: 0,
                    exp_first_wr: 4, exp_last_wr: NS + 3, exp_done: NS + 4, exp_busy: NS + 4};
        vecs[2] = '{lz: 1'b0, a_base: 5,     a_step: 3, b_base: 12280, b_step: 1,
                    exp_first_wr: 4, exp_last_wr: NS + 3, exp_done: NS + 4, exp_busy: NS + 4};

        // Reset state while reset is held.
        tick();
        tick();
        check("rst_busy",     int'(busy_s), 0);
        check("rst_done",     int'(done_s), 0);
        check("rst_rd_en",    int'(bus_s.rd_en), 0);
        check("rst_wr_en",    int'(bus_s.wr_en), 0);
        check("rst_add_load", int'(bus_s.add_load), 0);
        check("rst_add_lazy", int'(bus_s.add_lazy), 0);
        check("rst_add_en",   int'(bus_s.add_en), 0);
        check("rst_rd_addr",  int'(bus_s.rd_addr), 0);
        check("rst_wr_addr",  int'(bus_s.wr_addr), 0);
        reset = 1'b0;
        tick();
        check("idle_add_en",  int'(bus_s.add_en), 1);
        check("idle_busy",    int'(busy_s), 0);

        for (int i = 0; i < 3; i++) begin
            run_vec_s(vecs[i], $sformatf("vec%0d", i));
        end

        // A second start while busy is ignored and does not re-sample lazy.
        clear_s();
        for (int i = 0; i < NS; i++) begin
            mem_a_s[i] = 16'(12000 + i);
            mem_b_s[i] = 16'd300;
        end
        push_exp_s(1'b0);
        start_run_s(1'b0);
        tick();
        tick();
        start_s = 1'b1;
        lazy_s  = 1'b1;
        tick();
        start_s = 1'b0;
        lazy_s  = 1'b0;
        wait_done_s(1);
        repeat (6) tick();
        check("busy_start_writes", wr_cycs_s.size(), NS);
        check("busy_start_dones",  done_cycs_s.size(), 1);
        check("busy_start_lazy",   lazy_hi_s, 0);
        check("busy_start_sb",     sb_s.size(), 0);
        $display("[TB] start-while-busy: writes=%0d dones=%0d", wr_cycs_s.size(), done_cycs_s.size());

        // Start held through the DONE cycle: ignored in DONE, accepted in the following IDLE.
        begin
            int c0a, c0b, k;
            clear_s();
            push_exp_s(1'b0);
            start_run_s(1'b0);
            c0a = c0;
            k = 0;
            while (cyc - c0a < NS + 4 && k < 100) begin
                tick();
                k++;
            end
            start_s = 1'b1;
            push_exp_s(1'b0);
            tick();
            c0b = cyc;
            tick();
            start_s = 1'b0;
            wait_done_s(2);
            tick();
            check("b2b_dones",     done_cycs_s.size(), 2);
            check("b2b_writes",    wr_cycs_s.size(), 2 * NS);
            check("b2b_run1_done", first_of(done_cycs_s) - c0a, NS + 4);
            check("b2b_run2_wr0",  (wr_cycs_s.size() > NS) ? wr_cycs_s[NS] - c0b : -1000, 4);
            check("b2b_run2_done", last_of(done_cycs_s) - c0b, NS + 4);
            check("b2b_sb",        sb_s.size(), 0);
            $display("[TB] back-to-back: writes=%0d dones=%0d", wr_cycs_s.size(), done_cycs_s.size());
        end

        // Reset asserted during cycle 6 aborts the run immediately.
        clear_s();
        push_exp_s(1'b0);
        start_run_s(1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_s.delete();
        repeat (20) tick();
        check("rst_mid_writes", wr_cycs_s.size(), 2);
        check("rst_mid_reads",  rd_n_s, 5);
        check("rst_mid_dones",  done_cycs_s.size(), 0);
        check("rst_mid_busy",   int'(busy_s), 0);
        check("rst_mid_lazy",   int'(bus_s.add_lazy), 0);
        $display("[TB] reset mid-run: writes=%0d reads=%0d", wr_cycs_s.size(), rd_n_s);
        run_vec_s(vecs[0], "post_rst");

        // Full-size random reduced add.
        for (int i = 0; i < NF; i++) begin
            wr_t e;
            mem_a_f[i] = 16'($urandom_range(Q - 1, 0));
            mem_b_f[i] = 16'($urandom_range(Q - 1, 0));
            e.addr = 16'(i);
            e.data = exp_sum(int'(mem_a_f[i]), int'(mem_b_f[i]), 1'b0);
            sb_f.push_back(e);
        end
        start_f = 1'b1;
        lazy_f  = 1'b0;
        c0      = cyc;
        tick();
        start_f = 1'b0;
        begin
            int k;
            k = 0;
            while (done_n_f == 0 && k < NF + 200) begin
                tick();
                k++;
            end
            if (k >= NF + 200) begin
                tests++;
                fails++;
                $display("FAIL done_f_timeout: got %0d done pulses, expected 1", done_n_f);
            end
        end
        tick();
        check("full_first_wr", wr_first_f - c0, 4);
        check("full_done_cyc", done_cyc_f - c0, NF + 4);
        check("full_writes",   wr_n_f, NF);
        check("full_dones",    done_n_f, 1);
        check("full_sb",       sb_f.size(), 0);
        check("full_busy_end", int'(busy_f), 0);
        $display("[TB] full-size: writes=%0d data_errors=%0d done@%0d", wr_n_f, bad_f, done_cyc_f - c0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
